// File: rtl/pkt_tx_link.sv
// Transmit stage: plays one granted packet per grant as a framed beat stream, then an inter-frame gap.
// Optional per-class packet counters are enabled by defining PKT_TX_STATS_EN.
module pkt_tx_link #(
  parameter int LEN_W = 8,
  parameter int CH_W  = 4,
  parameter int IFG   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [LEN_W-1:0] pkt_len,
  input  logic [1:0]       active,
  input  logic [CH_W-1:0]  channel,
  output logic             link_ready,
  output logic             busy,
  output logic             tx_valid,
  output logic             tx_sof,
  output logic             tx_eof,
  output logic [CH_W-1:0]  tx_ch,
  output logic [1:0]       tx_class,
  output logic             done,
  output logic             err_grant,
  output logic [15:0]      stat_pkts_H,
  output logic [15:0]      stat_pkts_L,
  output logic [1:0]       dbg_state
);

  // Handshake: a grant is taken only on an edge where go=1 and link_ready=1 (IDLE);
  // a go seen while link_ready=0, or with class 00/11, is dropped and flags err_grant.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TX   = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [3:0] IFG_L  = 4'(IFG);
  localparam bit         NO_GAP = (IFG == 0);

  state_t           r_state;
  logic [LEN_W-1:0] r_cnt;
  logic [3:0]       r_gap;
  logic             r_link_ready;
  logic             r_busy;
  logic             r_tx_valid;
  logic             r_tx_sof;
  logic             r_tx_eof;
  logic [CH_W-1:0]  r_tx_ch;
  logic [1:0]       r_tx_class;
  logic             r_done;
  logic             r_err;
  logic             w_class_ok;

  assign w_class_ok = (active == 2'b01) || (active == 2'b10);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_gap        <= '0;
      r_link_ready <= 1'b1;
      r_busy       <= 1'b0;
      r_tx_valid   <= 1'b0;
      r_tx_sof     <= 1'b0;
      r_tx_eof     <= 1'b0;
      r_tx_ch      <= '0;
      r_tx_class   <= 2'b00;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (go) begin
            if (!w_class_ok) begin
              r_err <= 1'b1;
            end else if (pkt_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state      <= S_TX;
              r_cnt        <= pkt_len;
              r_tx_ch      <= channel;
              r_tx_class   <= active;
              r_tx_valid   <= 1'b1;
              r_tx_sof     <= 1'b1;
              r_tx_eof     <= (pkt_len == LEN_W'(1));
              r_link_ready <= 1'b0;
              r_busy       <= 1'b1;
            end
          end
        end
        S_TX: begin
          if (go) r_err <= 1'b1;
          // r_cnt holds the beats still to show, including the one on the link now
          if (r_cnt == LEN_W'(1)) begin
            r_tx_valid <= 1'b0;
            r_tx_sof   <= 1'b0;
            r_tx_eof   <= 1'b0;
            r_done     <= 1'b1;
            if (NO_GAP) begin
              r_state      <= S_IDLE;
              r_link_ready <= 1'b1;
              r_busy       <= 1'b0;
            end else begin
              r_state <= S_GAP;
              r_gap   <= IFG_L;
            end
          end else begin
            r_cnt    <= r_cnt - LEN_W'(1);
            r_tx_sof <= 1'b0;
            r_tx_eof <= (r_cnt == LEN_W'(2));
          end
        end
        S_GAP: begin
          if (go) r_err <= 1'b1;
          if (r_gap == 4'd1) begin
            r_state      <= S_IDLE;
            r_link_ready <= 1'b1;
            r_busy       <= 1'b0;
          end else begin
            r_gap <= r_gap - 4'd1;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_link_ready <= 1'b1;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

`ifdef PKT_TX_STATS_EN
  logic [15:0] r_stat_h;
  logic [15:0] r_stat_l;
  logic        w_last_beat;

  // Counts land in the same edge that raises done, so they are visible in the done cycle
  assign w_last_beat = (r_state == S_TX) && (r_cnt == LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_h <= '0;
      r_stat_l <= '0;
    end else if (w_last_beat) begin
      if (r_tx_class == 2'b01 && r_stat_h != 16'hFFFF) r_stat_h <= r_stat_h + 16'd1;
      if (r_tx_class == 2'b10 && r_stat_l != 16'hFFFF) r_stat_l <= r_stat_l + 16'd1;
    end
  end

  assign stat_pkts_H = r_stat_h;
  assign stat_pkts_L = r_stat_l;
`else
  assign stat_pkts_H = 16'd0;
  assign stat_pkts_L = 16'd0;
`endif

  assign link_ready = r_link_ready;
  assign busy       = r_busy;
  assign tx_valid   = r_tx_valid;
  assign tx_sof     = r_tx_sof;
  assign tx_eof     = r_tx_eof;
  assign tx_ch      = r_tx_ch;
  assign tx_class   = r_tx_class;
  assign done       = r_done;
  assign err_grant  = r_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_pkt_tx_link.sv
// Bench for pkt_tx_link: timeline model of accepted grants checked every cycle,
// a per-packet scoreboard on eof, and directed literal checks.
module tb_pkt_tx_link;
  localparam int LEN_W = 8;
  localparam int CH_W  = 4;
  localparam int IFG   = 2;
`ifdef PKT_TX_STATS_EN
  localparam int STATS_ON = 1;
`else
  localparam int STATS_ON = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             go = 1'b0;
  logic [LEN_W-1:0] pkt_len = '0;
  logic [1:0]       active = 2'b00;
  logic [CH_W-1:0]  channel = '0;
  logic             link_ready, busy, tx_valid, tx_sof, tx_eof, done, err_grant;
  logic [CH_W-1:0]  tx_ch;
  logic [1:0]       tx_class;
  logic [15:0]      stat_pkts_H, stat_pkts_L;
  logic [1:0]       dbg_state;

  pkt_tx_link #(.LEN_W(LEN_W), .CH_W(CH_W), .IFG(IFG)) dut (
    .clk(clk), .rst(rst), .go(go), .pkt_len(pkt_len), .active(active), .channel(channel),
    .link_ready(link_ready), .busy(busy), .tx_valid(tx_valid), .tx_sof(tx_sof),
    .tx_eof(tx_eof), .tx_ch(tx_ch), .tx_class(tx_class), .done(done),
    .err_grant(err_grant), .stat_pkts_H(stat_pkts_H), .stat_pkts_L(stat_pkts_L),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model: timeline of the last accepted grant ----------------
  bit             m_valid = 0;
  bit             m_have = 0;
  int             m_n = 0;
  int             m_len = 0;
  int             m_zdone = -10;
  logic [CH_W-1:0] m_ch = '0;
  logic [1:0]     m_cls = 2'b00;
  bit             m_err = 0;
  int             m_hb = 0;
  int             m_lb = 0;
  logic [CH_W+1:0] exp_q[$];

  function automatic bit m_busy(input int c);
    return m_have && c >= m_n + 1 && c <= m_n + m_len + IFG;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1; m_have = 0; m_n = 0; m_len = 0; m_zdone = -10;
      m_ch = '0; m_cls = 2'b00; m_err = 0; m_hb = 0; m_lb = 0;
      exp_q.delete();
    end else if (go) begin
      if (m_busy(cyc) || !(active == 2'b01 || active == 2'b10)) begin
        m_err = 1;
      end else if (pkt_len == 0) begin
        m_zdone = cyc + 1;
      end else begin
        if (m_have && m_cls == 2'b01) m_hb++;
        if (m_have && m_cls == 2'b10) m_lb++;
        m_have = 1; m_n = cyc; m_len = int'(pkt_len);
        m_ch = channel; m_cls = active;
        exp_q.push_back({active, channel});
      end
    end
    cyc++;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int c;
    bit fin;
    int eh, el;
    if (m_valid) begin
      c = cyc;
      fin = m_have && c >= m_n + m_len + 1;
      eh = (STATS_ON != 0) ? m_hb + ((fin && m_cls == 2'b01) ? 1 : 0) : 0;
      el = (STATS_ON != 0) ? m_lb + ((fin && m_cls == 2'b10) ? 1 : 0) : 0;
      check("link_ready", link_ready, !m_busy(c));
      check("busy", busy, m_busy(c));
      check("tx_valid", tx_valid, m_have && c >= m_n + 1 && c <= m_n + m_len);
      check("tx_sof", tx_sof, m_have && c == m_n + 1);
      check("tx_eof", tx_eof, m_have && c == m_n + m_len);
      check("done", done, (m_have && c == m_n + m_len + 1) || c == m_zdone);
      check("tx_ch", tx_ch, m_ch);
      check("tx_class", tx_class, m_cls);
      check("err_grant", err_grant, m_err);
      check("stat_pkts_H", stat_pkts_H, eh);
      check("stat_pkts_L", stat_pkts_L, el);
    end
  end

  // ---------------- monitor + scoreboard ----------------
  int beats = 0;
  int dones = 0;
  int last_sof = 0;
  int prev_sof = 0;
  int last_done = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid) beats++;
      if (tx_sof) begin prev_sof = last_sof; last_sof = cyc; end
      if (done) begin dones++; last_done = cyc; end
      if (tx_valid && tx_eof) begin
        if (exp_q.size() == 0) check("sb_unexpected_eof", 1, 0);
        else check("sb_class_ch", {tx_class, tx_ch}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic go_pulse(input int len, input logic [1:0] cls, input int ch);
    go = 1'b1; pkt_len = LEN_W'(len); active = cls; channel = CH_W'(ch);
    @(posedge clk); #1;
    go = 1'b0; pkt_len = '0; active = 2'b00; channel = '0;
  endtask

  task automatic wait_ready(input int budget);
    int k;
    k = 0;
    while (!link_ready && k < budget) begin step(1); k++; end
    check("wait_ready", link_ready, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    check("reset_link_ready", link_ready, 1);
    check("reset_tx_valid", tx_valid, 0);
    check("reset_err", err_grant, 0);

    // 4-beat H packet on channel 3
    beats = 0;
    go_pulse(4, 2'b01, 3);
    check("t1_sof", tx_sof, 1);
    check("t1_ch", tx_ch, 3);
    wait_ready(50);
    check("t1_beats", beats, 4);
    check("t1_sof_to_done", last_done - last_sof, 4);
    check("t1_sof_to_ready", cyc - last_sof, 6);
    check("t1_stat_h", stat_pkts_H, STATS_ON);

    // single-beat L packet
    go_pulse(1, 2'b10, 5);
    check("t2_sof_eof", {tx_sof, tx_eof}, 2'b11);
    step(1);
    check("t2_done", done, 1);
    wait_ready(50);

    // zero-length grant
    go_pulse(0, 2'b01, 7);
    check("t3_done", done, 1);
    check("t3_ready", link_ready, 1);
    check("t3_stat_h", stat_pkts_H, STATS_ON);
    step(1);
    check("t3_done_once", done, 0);

    // grant during beat 4 of an 8-beat L packet
    beats = 0;
    go_pulse(8, 2'b10, 9);
    step(3);
    go_pulse(5, 2'b01, 2);
    check("t4_err", err_grant, 1);
    check("t4_ch_kept", tx_ch, 9);
    wait_ready(50);
    check("t4_beats", beats, 8);
    check("t4_err_sticky", err_grant, 1);

    // back-to-back on the first link_ready cycle
    go_pulse(3, 2'b01, 4);
    wait_ready(50);
    go_pulse(2, 2'b10, 1);
    step(3);
    check("t5_sof_spacing", last_sof - prev_sof, 6);
    wait_ready(50);

    // reset on beat 3 of 8
    go_pulse(8, 2'b01, 6);
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    dones = 0;
    check("t6_valid", tx_valid, 0);
    check("t6_ready", link_ready, 1);
    check("t6_err", err_grant, 0);
    check("t6_ch", tx_ch, 0);
    step(12);
    check("t6_no_done", dones, 0);
    beats = 0;
    go_pulse(2, 2'b10, 3);
    wait_ready(50);
    check("t6_after_beats", beats, 2);

    // reserved class
    go_pulse(3, 2'b11, 1);
    check("t7_err", err_grant, 1);
    step(2);
    check("t7_no_beat", tx_valid, 0);

    // maximum length
    beats = 0;
    go_pulse(255, 2'b01, 15);
    wait_ready(600);
    check("t8_beats", beats, 255);

    step(3);
    check("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pkt_tx_link.md
# pkt_tx_link

Downstream transmit stage of the fixed-priority/round-robin scheduler. It consumes each grant (`go` pulse with `pkt_len`, `active` class and `channel`) and plays the granted packet onto the link as a framed beat stream, one beat per clock for `pkt_len` cycles. After each packet it enforces an inter-frame gap, then reports completion back to the queue servers. Link occupancy is exposed so the scheduler holds further grants while the link is busy.

## Interface
- `LEN_W`, 8, width of `pkt_len` and internal beat counter
- `CH_W`, 4, width of `channel` / `tx_ch`
- `IFG`, 2, inter-frame gap in clock cycles (0..15)
- `clk` in 1 — single clock, all logic on rising edge
- `rst` in 1 — reset; synchronous, active-high
- `go` in 1 — grant pulse from scheduler, sampled every edge
- `pkt_len` in LEN_W — packet length in beats, valid with `go`
- `active` in 2 — granted class: 00 none, 01 H, 10 L, 11 reserved
- `channel` in CH_W — granted channel index, valid with `go`
- `link_ready` out 1 — high when IDLE; scheduler issues `go` only while high
- `busy` out 1 — high in TX and GAP
- `tx_valid` out 1 — beat on link this cycle
- `tx_sof` out 1 — first beat of packet
- `tx_eof` out 1 — last beat of packet
- `tx_ch` out CH_W — channel of packet in flight, held for whole packet
- `tx_class` out 2 — `active` of packet in flight, held for whole packet
- `done` out 1 — one-cycle completion pulse
- `err_grant` out 1 — sticky protocol error flag
- `stat_pkts_H`, `stat_pkts_L` out 16 — packets sent per class (see Configuration)

## Operation
- States: IDLE, TX, GAP.
- IDLE: `link_ready`=1. On `go`=1 with `active` in {01,10} and `pkt_len`≠0: latch `pkt_len`, `channel`, `active`; load beat counter with `pkt_len`; go to TX.
- `go` with `pkt_len`=0: no beats; `done` pulses next cycle; stay IDLE; no gap; not counted in stats.
- `go` with `active`=00 or 11: ignored, `err_grant` set.
- TX: `tx_valid`=1 each cycle; counter decrements per beat; `tx_sof` on first beat, `tx_eof` when counter=1 (`sof` and `eof` both high when `pkt_len`=1). After the eof beat go to GAP, or to IDLE when `IFG`=0.
- GAP: count `IFG` cycles with `tx_valid`=0, then return to IDLE.
- `go` while not IDLE: ignored (no effect on packet in flight), `err_grant` set.
- `err_grant` stays set until `rst`.
- `pkt_len`=2^LEN_W−1 (255) is legal; the counter never wraps.
- Reset (including mid-packet): state IDLE. Outputs after reset: `link_ready`=1; `busy`, `tx_valid`, `tx_sof`, `tx_eof`, `done`, `err_grant` = 0; `tx_ch`=0; `tx_class`=00; stats=0. Any packet in flight is abandoned with no `done`.

## Timing
- `go` sampled at edge N → first beat (`tx_valid`, `tx_sof`) registered at edge N+1. Beats occupy cycles N+1..N+L.
- `done` is high in cycle N+L+1, a single cycle, coincident with the first GAP cycle.
- `busy` is high N+1..N+L+IFG. `link_ready` returns high in cycle N+L+IFG+1, so a back-to-back `go` is accepted at that edge.
- Minimum grant-to-grant spacing is L+IFG+1 cycles.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- Macro `PKT_TX_STATS_EN`.
- Defined: `stat_pkts_H` / `stat_pkts_L` increment by 1 in the `done` cycle of each H / L packet. They saturate at 0xFFFF and clear on `rst`.
- Undefined: no counter logic; both outputs are tied to 0.

## Test plan
- Reset, then `go` with `pkt_len`=4, `active`=01, `channel`=3 → `tx_valid` for 4 cycles, `tx_sof` on beat 1, `tx_eof` on beat 4, `tx_ch`=3, `done` in cycle 5, `link_ready` back after 2 gap cycles; `stat_pkts_H`=1.
- `pkt_len`=1 → single beat with `sof`=`eof`=1; `done` in the next cycle.
- `pkt_len`=0 → no beats; `done` in the next cycle; `link_ready` stays 1; stats unchanged.
- `go` at the mid-packet beat of an 8-beat L packet → stream unchanged; `err_grant`=1 and stays set.
- Back-to-back: `go` issued on the first `link_ready` cycle after a 3-beat packet with `IFG`=2 → new `sof` exactly 6 cycles after the previous `sof`.
- `rst` asserted on beat 3 of 8 → next cycle all outputs at reset values; no `done`; a following `go` with `pkt_len`=2 runs normally.
